// File: rtl/as_master_bpi_if.sv
// Wishbone classic bus bundle between the core-side master BPI and the slave BPIs.
interface as_master_bpi_if #(
  parameter int unsigned addr_width = 64,
  parameter int unsigned data_width = 64,
  parameter int unsigned sel_width  = 8
);
  logic [addr_width-1:0] wb_addr_o;
  logic [data_width-1:0] wb_dat_o;
  logic [data_width-1:0] wb_dat_i;
  logic                  wb_we_o;
  logic [sel_width-1:0]  wb_sel_o;
  logic                  wb_stb_o;
  logic                  wb_cyc_o;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    output wb_addr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_addr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/as_master_bpi.sv
// Wishbone master BPI: turns one core load/store into a single classic Wishbone
// cycle with byte-lane steering, then returns extended load data and a done pulse.
module as_master_bpi #(
  parameter int unsigned addr_width     = 64,
  parameter int unsigned data_width     = 64,
  parameter int unsigned sel_width      = 8,
  parameter int unsigned timeout_cycles = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] addr_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [data_width-1:0] wdata_i,
  output logic [data_width-1:0] rdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  as_master_bpi_if.master       wb
);

  localparam int unsigned CNT_W = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [addr_width-1:0] wb_addr_q, wb_addr_d;
  logic [data_width-1:0] wb_dat_q, wb_dat_d;
  logic [sel_width-1:0]  wb_sel_q, wb_sel_d;
  logic                  wb_we_q, wb_we_d;
  logic                  wb_cyc_q, wb_cyc_d;
  logic                  wb_stb_q, wb_stb_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [2:0]            off_q, off_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic [2:0]            align_mask_c;
  logic                  misaligned_c;
  logic [sel_width-1:0]  lanes_c;
  logic [data_width-1:0] shifted_c;
  logic [data_width-1:0] load_c;
  logic                  ext_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wb_addr_q <= '0;
      wb_dat_q  <= '0;
      wb_sel_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_cyc_q  <= 1'b0;
      wb_stb_q  <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      off_q     <= 3'b000;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_addr_q <= wb_addr_d;
      wb_dat_q  <= wb_dat_d;
      wb_sel_q  <= wb_sel_d;
      wb_we_q   <= wb_we_d;
      wb_cyc_q  <= wb_cyc_d;
      wb_stb_q  <= wb_stb_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Request sizing, load extraction and next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_addr_d = wb_addr_q;
    wb_dat_d  = wb_dat_q;
    wb_sel_d  = wb_sel_q;
    wb_we_d   = wb_we_q;
    wb_cyc_d  = wb_cyc_q;
    wb_stb_d  = wb_stb_q;
    size_d    = size_q;
    uns_d     = uns_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    done_d    = 1'b0;
    busy_d    = busy_q;

    align_mask_c = 3'((4'd1 << size_i) - 4'd1);
    misaligned_c = |(addr_i[2:0] & align_mask_c);

    case (size_i)
      2'b00:   lanes_c = sel_width'(8'h01);
      2'b01:   lanes_c = sel_width'(8'h03);
      2'b10:   lanes_c = sel_width'(8'h0F);
      default: lanes_c = sel_width'(8'hFF);
    endcase

    // Extension bit is zero for unsigned loads so one expression covers both.
    shifted_c = wb.wb_dat_i >> {off_q, 3'b000};
    case (size_q)
      2'b00: begin
        ext_c  = shifted_c[7] & ~uns_q;
        load_c = {{(data_width-8){ext_c}}, shifted_c[7:0]};
      end
      2'b01: begin
        ext_c  = shifted_c[15] & ~uns_q;
        load_c = {{(data_width-16){ext_c}}, shifted_c[15:0]};
      end
      2'b10: begin
        ext_c  = shifted_c[31] & ~uns_q;
        load_c = {{(data_width-32){ext_c}}, shifted_c[31:0]};
      end
      default: begin
        ext_c  = 1'b0;
        load_c = shifted_c;
      end
    endcase

    case (state_q)
      IDLE: begin
        if (req_i) begin
          busy_d = 1'b1;
          if (misaligned_c) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d   = BUS;
            wb_addr_d = {addr_i[addr_width-1:3], 3'b000};
            wb_sel_d  = lanes_c << addr_i[2:0];
            wb_dat_d  = wdata_i << {addr_i[2:0], 3'b000};
            wb_we_d   = we_i;
            wb_cyc_d  = 1'b1;
            wb_stb_d  = 1'b1;
            cnt_d     = '0;
            size_d    = size_i;
            uns_d     = unsigned_i;
            off_d     = addr_i[2:0];
          end
        end
      end
      BUS: begin
        if (wb.wb_err_i || (!wb.wb_ack_i && cnt_q == CNT_W'(timeout_cycles - 1))) begin
          state_d  = RESP;
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_we_d  = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          rdata_d  = '0;
        end else if (wb.wb_ack_i) begin
          state_d  = RESP;
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_we_d  = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b0;
          rdata_d  = wb_we_q ? '0 : load_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign rdata_o      = rdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign wb.wb_addr_o = wb_addr_q;
  assign wb.wb_dat_o  = wb_dat_q;
  assign wb.wb_sel_o  = wb_sel_q;
  assign wb.wb_we_o   = wb_we_q;
  assign wb.wb_cyc_o  = wb_cyc_q;
  assign wb.wb_stb_o  = wb_stb_q;

endmodule

// File: tb/tb_as_master_bpi.sv
// Scoreboard bench for as_master_bpi: directed requests push expected bus and
// completion records; monitors pop and compare when the DUT presents them.
module tb_as_master_bpi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [63:0] addr = '0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        busy, done, err;

  logic [63:0] slv_data = '0;
  logic        ack_en = 1'b0;
  logic        err_en = 1'b0;
  int          ack_wait = 0;
  int          stb_cnt = 0;
  int          stb_total = 0;
  int          stb_rises = 0;
  int          done_count = 0;
  int          done_cyc = 0;
  int          cyc_n = 0;
  int          req_cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        stb_prev = 1'b0;
  logic [63:0] cap_addr, cap_dat;
  logic [7:0]  cap_sel;
  logic        cap_we;

  typedef struct { logic [63:0] rdata; logic err; } done_exp_t;
  typedef struct { logic [63:0] addr; logic [7:0] sel; logic [63:0] dat; logic we; } bus_exp_t;
  done_exp_t done_q[$];
  bus_exp_t  bus_q[$];

  as_master_bpi_if #(.addr_width(64), .data_width(64), .sel_width(8)) wbif ();

  as_master_bpi #(.addr_width(64), .data_width(64), .sel_width(8), .timeout_cycles(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .size_i(size),
    .unsigned_i(uns), .wdata_i(wdata), .rdata_o(rdata), .busy_o(busy), .done_o(done),
    .err_o(err), .wb(wbif)
  );

  always #5 clk = ~clk;

  // Slave model: acks/errs combinationally once stb has been high ack_wait cycles.
  assign wbif.wb_dat_i = slv_data;
  assign wbif.wb_ack_i = wbif.wb_stb_o && ack_en && (stb_cnt == ack_wait);
  assign wbif.wb_err_i = wbif.wb_stb_o && err_en && (stb_cnt == ack_wait);

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (wbif.wb_stb_o) stb_total <= stb_total + 1;
    if (wbif.wb_stb_o && !wbif.wb_ack_i && !wbif.wb_err_i) stb_cnt <= stb_cnt + 1;
    else stb_cnt <= 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus monitor: compares each new strobe to the scoreboard and checks stability.
  always @(negedge clk) begin
    if (wbif.wb_stb_o && !stb_prev) begin
      bus_exp_t b;
      stb_rises++;
      cap_addr = wbif.wb_addr_o; cap_sel = wbif.wb_sel_o;
      cap_dat  = wbif.wb_dat_o;  cap_we  = wbif.wb_we_o;
      if (bus_q.size() == 0) begin
        chk("unexpected_stb", 64'd1, 64'd0);
      end else begin
        b = bus_q.pop_front();
        chk("wb_addr", wbif.wb_addr_o, b.addr);
        chk("wb_sel", 64'(wbif.wb_sel_o), 64'(b.sel));
        chk("wb_dat", wbif.wb_dat_o, b.dat);
        chk("wb_we", 64'(wbif.wb_we_o), 64'(b.we));
        chk("wb_cyc", 64'(wbif.wb_cyc_o), 64'd1);
      end
    end else if (wbif.wb_stb_o) begin
      chk("bus_stable", {wbif.wb_addr_o ^ cap_addr} | {56'd0, wbif.wb_sel_o ^ cap_sel}
          | (wbif.wb_dat_o ^ cap_dat) | 64'(wbif.wb_we_o ^ cap_we), 64'd0);
    end
    stb_prev = wbif.wb_stb_o;
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (done) begin
      done_exp_t d;
      done_count++;
      done_cyc = cyc_n;
      if (done_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        d = done_q.pop_front();
        chk("rdata", rdata, d.rdata);
        chk("err", 64'(err), 64'(d.err));
        chk("busy_in_resp", 64'(busy), 64'd1);
      end
    end
  end

  task automatic issue(input logic iwe, input logic [63:0] iaddr, input logic [1:0] isize,
                       input logic iuns, input logic [63:0] iwdata,
                       input logic exp_bus, input logic [63:0] eaddr, input logic [7:0] esel,
                       input logic [63:0] edat,
                       input logic exp_done, input logic [63:0] erdata, input logic eerr);
    bus_exp_t  b;
    done_exp_t d;
    @(posedge clk); #1;
    we = iwe; addr = iaddr; size = isize; uns = iuns; wdata = iwdata; req = 1'b1;
    req_cyc = cyc_n;
    if (exp_bus) begin
      b.addr = eaddr; b.sel = esel; b.dat = edat; b.we = iwe;
      bus_q.push_back(b);
    end
    if (exp_done) begin
      d.rdata = erdata; d.err = eerr;
      done_q.push_back(d);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(input int start, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      if (done_count != start) seen = 1'b1;
    end
    if (!seen) chk({name, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int d0, s0, r0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cyc_stb_we", {61'd0, wbif.wb_cyc_o, wbif.wb_stb_o, wbif.wb_we_o}, 64'd0);
    chk("rst_sel", 64'(wbif.wb_sel_o), 64'd0);
    chk("rst_addr", wbif.wb_addr_o, 64'd0);
    chk("rst_dat", wbif.wb_dat_o, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst = 1'b0;

    // Dword load, zero-wait slave.
    ack_en = 1'b1; ack_wait = 0; slv_data = 64'h1122334455667788;
    d0 = done_count; s0 = stb_total;
    issue(1'b0, 64'h1000, 2'b11, 1'b0, 64'd0, 1'b1, 64'h1000, 8'hFF, 64'd0,
          1'b1, 64'h1122334455667788, 1'b0);
    wait_done(d0, "dword");
    chk("dword_latency", 64'(done_cyc - req_cyc), 64'd2);
    chk("dword_stb_cycles", 64'(stb_total - s0), 64'd1);

    // Signed then unsigned byte load from lane 5.
    slv_data = 64'h0000800000000000;
    d0 = done_count;
    issue(1'b0, 64'h1005, 2'b00, 1'b0, 64'd0, 1'b1, 64'h1000, 8'h20, 64'd0,
          1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0);
    wait_done(d0, "sbyte");
    d0 = done_count;
    issue(1'b0, 64'h1005, 2'b00, 1'b1, 64'd0, 1'b1, 64'h1000, 8'h20, 64'd0,
          1'b1, 64'h80, 1'b0);
    wait_done(d0, "ubyte");

    // Half store with 3 wait cycles.
    ack_wait = 3;
    d0 = done_count;
    issue(1'b1, 64'h2002, 2'b01, 1'b0, 64'hABCD, 1'b1, 64'h2000, 8'h0C, 64'h00000000ABCD0000,
          1'b1, 64'd0, 1'b0);
    wait_done(d0, "hstore");
    chk("hstore_latency", 64'(done_cyc - req_cyc), 64'd5);

    // Misaligned word load: no bus cycle, error one cycle later.
    ack_wait = 0;
    d0 = done_count; r0 = stb_rises;
    issue(1'b0, 64'h3002, 2'b10, 1'b0, 64'd0, 1'b0, 64'd0, 8'd0, 64'd0,
          1'b1, 64'd0, 1'b1);
    wait_done(d0, "misal");
    chk("misal_latency", 64'(done_cyc - req_cyc), 64'd1);
    chk("misal_no_stb", 64'(stb_rises - r0), 64'd0);

    // Timeout: slave never responds.
    ack_en = 1'b0;
    d0 = done_count; s0 = stb_total;
    issue(1'b0, 64'h4000, 2'b11, 1'b0, 64'd0, 1'b1, 64'h4000, 8'hFF, 64'd0,
          1'b1, 64'd0, 1'b1);
    wait_done(d0, "timeout");
    chk("timeout_stb_cycles", 64'(stb_total - s0), 64'd16);
    chk("timeout_latency", 64'(done_cyc - req_cyc), 64'd17);

    // Error together with ack: error wins.
    ack_en = 1'b1; err_en = 1'b1; slv_data = 64'hDEADBEEFDEADBEEF;
    d0 = done_count;
    issue(1'b0, 64'h5008, 2'b11, 1'b0, 64'd0, 1'b1, 64'h5008, 8'hFF, 64'd0,
          1'b1, 64'd0, 1'b1);
    wait_done(d0, "err_ack");
    err_en = 1'b0;

    // Prime rdata, then reset during the second wait cycle of a bus access.
    d0 = done_count; slv_data = 64'h00000000CAFEF00D;
    issue(1'b0, 64'h6000, 2'b11, 1'b0, 64'd0, 1'b1, 64'h6000, 8'hFF, 64'd0,
          1'b1, 64'h00000000CAFEF00D, 1'b0);
    wait_done(d0, "prime");
    ack_wait = 10;
    d0 = done_count;
    issue(1'b0, 64'h6000, 2'b11, 1'b0, 64'd0, 1'b1, 64'h6000, 8'hFF, 64'd0,
          1'b0, 64'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_cyc", 64'(wbif.wb_cyc_o), 64'd0);
    chk("rst_mid_stb", 64'(wbif.wb_stb_o), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_rdata", rdata, 64'd0);
    repeat (5) @(posedge clk);
    chk("rst_mid_no_done", 64'(done_count - d0), 64'd0);

    // Signed word load after reset.
    ack_wait = 0; slv_data = 64'h8765432100000000;
    d0 = done_count;
    issue(1'b0, 64'h7004, 2'b10, 1'b0, 64'd0, 1'b1, 64'h7000, 8'hF0, 64'd0,
          1'b1, 64'hFFFFFFFF87654321, 1'b0);
    wait_done(d0, "post_rst");

    // Request pulsed while busy must be ignored.
    ack_wait = 2; slv_data = 64'hBEEF000000000000;
    d0 = done_count; r0 = stb_rises;
    issue(1'b0, 64'h8006, 2'b01, 1'b1, 64'd0, 1'b1, 64'h8000, 8'hC0, 64'd0,
          1'b1, 64'h000000000000BEEF, 1'b0);
    addr = 64'h9000; size = 2'b11; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_done(d0, "busy_req");
    repeat (6) @(posedge clk);
    chk("busy_req_one_stb", 64'(stb_rises - r0), 64'd1);
    chk("busy_req_one_done", 64'(done_count - d0), 64'd1);

    chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
